// File: rtl/lsu_mem_ctrl_if.sv
// Bus bundle between the LSQ head, the data-cache port and the CDB result slot.
// Ports:
//   req_*  : one load/store request from the LSQ head (valid/ready handshake)
//   flush  : mispredict flush
//   dmem_* : data-cache port (word address, byte masks, shifted wdata, response)
//   res_*  : one result toward the CDB slot plus RVFI memory fields
// Modports: master = the memory controller, slave = LSQ head + cache + CDB side.
interface lsu_mem_ctrl_if #(
  parameter int unsigned ROB_D = 8
);
  localparam int unsigned TAG_W = $clog2(ROB_D);

  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [TAG_W-1:0]  req_rob_id;

  logic [31:0]       dmem_addr;
  logic [3:0]        dmem_rmask;
  logic [3:0]        dmem_wmask;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_resp;

  logic              res_valid;
  logic              res_ready;
  logic [TAG_W-1:0]  res_rob_id;
  logic [31:0]       res_value;
  logic              res_is_store;
  logic              res_misalign;
  logic [31:0]       res_addr;
  logic [3:0]        res_rmask;
  logic [3:0]        res_wmask;
  logic [31:0]       res_rdata;
  logic [31:0]       res_wdata;

  modport master (
    input  flush, req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rob_id,
    input  dmem_rdata, dmem_resp, res_ready,
    output req_ready,
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output res_valid, res_rob_id, res_value, res_is_store, res_misalign,
    output res_addr, res_rmask, res_wmask, res_rdata, res_wdata
  );

  modport slave (
    output flush, req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rob_id,
    output dmem_rdata, dmem_resp, res_ready,
    input  req_ready,
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  res_valid, res_rob_id, res_value, res_is_store, res_misalign,
    input  res_addr, res_rmask, res_wmask, res_rdata, res_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Memory-access back end of the load/store queue: takes one load or store from
// the LSQ head, drives the data-cache port, waits for the response, extends
// load data and holds one result for the CDB slot with RVFI memory fields.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : lsu_mem_ctrl_if.master (request, cache port, result)
module lsu_mem_ctrl #(
  parameter int unsigned ROB_D = 8
) (
  input  logic              clk,
  input  logic              rst,
  lsu_mem_ctrl_if.master    bus
);
  localparam int unsigned TAG_W = $clog2(ROB_D);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_n;
  logic              killed, killed_n;

  // Request context kept for the cache response
  logic              r_is_store;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic [TAG_W-1:0]  r_rob_id;

  logic [1:0]        req_off_c;
  logic [3:0]        req_mask_c;
  logic              req_misalign_c;
  logic [31:0]       req_wdata_sh_c;
  logic              accept_c;
  logic              kill_c;
  logic [31:0]       load_val_c;

  // Sign/zero extension of the addressed byte/half out of the raw word
  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{off, 3'b000} +: 8];
    h = d[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'd0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = d;
    endcase
  endfunction

  // Request decode: byte lanes, alignment, lane-shifted store data
  assign req_off_c = bus.req_addr[1:0];

  always_comb begin
    req_mask_c     = 4'b1111;
    req_misalign_c = 1'b0;
    case (bus.req_funct3[1:0])
      2'b00: req_mask_c = 4'b0001 << req_off_c;
      2'b01: begin
        req_mask_c     = 4'b0011 << req_off_c;
        req_misalign_c = req_off_c[0];
      end
      default: begin
        req_mask_c     = 4'b1111;
        req_misalign_c = (req_off_c != 2'b00);
      end
    endcase
  end

  assign req_wdata_sh_c = bus.req_wdata << {req_off_c, 3'b000};

  assign bus.req_ready = (state == IDLE) & ~bus.flush & ~rst;
  assign accept_c      = bus.req_valid & bus.req_ready;
  // Flush only hits loads; committed stores always finish
  assign kill_c        = bus.flush & ~r_is_store;
  assign load_val_c    = r_is_store ? 32'd0 : load_ext(bus.dmem_rdata, r_funct3, r_off);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      killed <= 1'b0;
    end else begin
      state  <= state_n;
      killed <= killed_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n  = state;
    killed_n = killed;
    case (state)
      IDLE: begin
        killed_n = 1'b0;
        if (accept_c) state_n = req_misalign_c ? DONE : MEM;
      end
      MEM: begin
        // The cache cannot abort: a killed load still waits for its response
        if (bus.dmem_resp) begin
          killed_n = 1'b0;
          state_n  = (killed | kill_c) ? IDLE : DONE;
        end else if (kill_c) begin
          killed_n = 1'b1;
        end
      end
      DONE: begin
        if (kill_c | bus.res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Cache port, request context and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_store       <= 1'b0;
      r_funct3         <= 3'd0;
      r_off            <= 2'd0;
      r_rob_id         <= '0;
      bus.dmem_addr    <= 32'd0;
      bus.dmem_rmask   <= 4'd0;
      bus.dmem_wmask   <= 4'd0;
      bus.dmem_wdata   <= 32'd0;
      bus.res_valid    <= 1'b0;
      bus.res_rob_id   <= '0;
      bus.res_value    <= 32'd0;
      bus.res_is_store <= 1'b0;
      bus.res_misalign <= 1'b0;
      bus.res_addr     <= 32'd0;
      bus.res_rmask    <= 4'd0;
      bus.res_wmask    <= 4'd0;
      bus.res_rdata    <= 32'd0;
      bus.res_wdata    <= 32'd0;
    end else begin
      if (accept_c) begin
        r_is_store <= bus.req_is_store;
        r_funct3   <= bus.req_funct3;
        r_off      <= req_off_c;
        r_rob_id   <= bus.req_rob_id;
      end

      // Cache port is live only for aligned accesses, up to and including the response cycle
      if (accept_c && !req_misalign_c) begin
        bus.dmem_addr  <= {bus.req_addr[31:2], 2'b00};
        bus.dmem_rmask <= bus.req_is_store ? 4'd0 : req_mask_c;
        bus.dmem_wmask <= bus.req_is_store ? req_mask_c : 4'd0;
        bus.dmem_wdata <= bus.req_is_store ? req_wdata_sh_c : 32'd0;
      end else if (state == MEM && bus.dmem_resp) begin
        bus.dmem_addr  <= 32'd0;
        bus.dmem_rmask <= 4'd0;
        bus.dmem_wmask <= 4'd0;
        bus.dmem_wdata <= 32'd0;
      end

      // Result: loaded on entry to DONE, cleared on leaving it
      if (accept_c && req_misalign_c) begin
        bus.res_valid    <= 1'b1;
        bus.res_rob_id   <= bus.req_rob_id;
        bus.res_value    <= 32'd0;
        bus.res_is_store <= bus.req_is_store;
        bus.res_misalign <= 1'b1;
        bus.res_addr     <= {bus.req_addr[31:2], 2'b00};
        bus.res_rmask    <= 4'd0;
        bus.res_wmask    <= 4'd0;
        bus.res_rdata    <= 32'd0;
        bus.res_wdata    <= 32'd0;
      end else if (state == MEM && state_n == DONE) begin
        bus.res_valid    <= 1'b1;
        bus.res_rob_id   <= r_rob_id;
        bus.res_value    <= load_val_c;
        bus.res_is_store <= r_is_store;
        bus.res_misalign <= 1'b0;
        bus.res_addr     <= bus.dmem_addr;
        bus.res_rmask    <= bus.dmem_rmask;
        bus.res_wmask    <= bus.dmem_wmask;
        bus.res_rdata    <= bus.dmem_rdata;
        bus.res_wdata    <= bus.dmem_wdata;
      end else if (state == DONE && state_n == IDLE) begin
        bus.res_valid    <= 1'b0;
        bus.res_rob_id   <= '0;
        bus.res_value    <= 32'd0;
        bus.res_is_store <= 1'b0;
        bus.res_misalign <= 1'b0;
        bus.res_addr     <= 32'd0;
        bus.res_rmask    <= 4'd0;
        bus.res_wmask    <= 4'd0;
        bus.res_rdata    <= 32'd0;
        bus.res_wdata    <= 32'd0;
      end
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl. Inputs change 1ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_lsu_mem_ctrl;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  lsu_mem_ctrl_if #(.ROB_D(8)) bus ();
  lsu_mem_ctrl #(.ROB_D(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] rob);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_rob_id   = rob;
  endtask

  // Aligned access with response after k cycles in MEM; starts and ends in IDLE at edge+1
  task automatic run_access(input string name, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] rob, input logic [31:0] rdata, input int k,
                            input logic [3:0] exp_mask, input logic [31:0] exp_wd,
                            input logic [31:0] exp_val);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    drive_req(st, f3, addr, wdata, rob);
    @(negedge clk);
    check_val({name, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    for (int c = 1; c <= k; c++) begin
      if (c == k) begin
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = rdata;
      end
      @(negedge clk);
      check_val($sformatf("%s_rmask_c%0d", name, c), 32'(bus.dmem_rmask), st ? 32'd0 : 32'(exp_mask));
      check_val($sformatf("%s_wmask_c%0d", name, c), 32'(bus.dmem_wmask), st ? 32'(exp_mask) : 32'd0);
      check_val($sformatf("%s_addr_c%0d", name, c), bus.dmem_addr, waddr);
      check_val($sformatf("%s_wdata_c%0d", name, c), bus.dmem_wdata, st ? exp_wd : 32'd0);
      step();
      bus.dmem_resp = 1'b0;
    end
    @(negedge clk);
    check_val({name, "_res_valid"}, 32'(bus.res_valid), 32'd1);
    check_val({name, "_res_value"}, bus.res_value, exp_val);
    check_val({name, "_res_is_store"}, 32'(bus.res_is_store), 32'(st));
    check_val({name, "_res_misalign"}, 32'(bus.res_misalign), 32'd0);
    check_val({name, "_res_rob_id"}, 32'(bus.res_rob_id), 32'(rob));
    check_val({name, "_res_addr"}, bus.res_addr, waddr);
    check_val({name, "_res_rmask"}, 32'(bus.res_rmask), st ? 32'd0 : 32'(exp_mask));
    check_val({name, "_res_wmask"}, 32'(bus.res_wmask), st ? 32'(exp_mask) : 32'd0);
    if (st) check_val({name, "_res_wdata"}, bus.res_wdata, exp_wd);
    else    check_val({name, "_res_rdata"}, bus.res_rdata, rdata);
    check_val({name, "_rmask_after"}, 32'(bus.dmem_rmask), 32'd0);
    check_val({name, "_wmask_after"}, 32'(bus.dmem_wmask), 32'd0);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    @(negedge clk);
    check_val({name, "_res_valid_drop"}, 32'(bus.res_valid), 32'd0);
    check_val({name, "_ready_again"}, 32'(bus.req_ready), 32'd1);
    step();
  endtask

  // Misaligned access: straight to DONE, cache port never touched
  task automatic mis_access(input string name, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [2:0] rob);
    drive_req(st, f3, addr, 32'hFFFF_FFFF, rob);
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_val({name, "_res_valid"}, 32'(bus.res_valid), 32'd1);
    check_val({name, "_res_misalign"}, 32'(bus.res_misalign), 32'd1);
    check_val({name, "_res_value"}, bus.res_value, 32'd0);
    check_val({name, "_res_is_store"}, 32'(bus.res_is_store), 32'(st));
    check_val({name, "_res_rob_id"}, 32'(bus.res_rob_id), 32'(rob));
    check_val({name, "_res_masks"}, 32'({bus.res_rmask, bus.res_wmask}), 32'd0);
    check_val({name, "_dmem_masks"}, 32'({bus.dmem_rmask, bus.dmem_wmask}), 32'd0);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    @(negedge clk);
    check_val({name, "_res_valid_drop"}, 32'(bus.res_valid), 32'd0);
    check_val({name, "_dmem_masks_after"}, 32'({bus.dmem_rmask, bus.dmem_wmask}), 32'd0);
    step();
  endtask

  // Word access, flush at cycle 2, response at cycle 4
  task automatic flush_case(input string name, input logic st);
    logic [3:0] rm;
    logic [3:0] wm;
    rm = st ? 4'b0000 : 4'b1111;
    wm = st ? 4'b1111 : 4'b0000;
    drive_req(st, 3'b010, 32'h0000_4000, 32'h1234_5678, 3'd5);
    step();
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) bus.flush = 1'b1;
      if (c == 4) begin
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      check_val($sformatf("%s_masks_c%0d", name, c), 32'({bus.dmem_rmask, bus.dmem_wmask}), 32'({rm, wm}));
      step();
      bus.flush     = 1'b0;
      bus.dmem_resp = 1'b0;
    end
    @(negedge clk);
    check_val({name, "_res_valid_c5"}, 32'(bus.res_valid), 32'(st));
    check_val({name, "_masks_c5"}, 32'({bus.dmem_rmask, bus.dmem_wmask}), 32'd0);
    check_val({name, "_req_ready_c5"}, 32'(bus.req_ready), 32'(!st));
    if (st) begin
      check_val({name, "_res_is_store"}, 32'(bus.res_is_store), 32'd1);
      check_val({name, "_res_wdata"}, bus.res_wdata, 32'h1234_5678);
      check_val({name, "_res_value"}, bus.res_value, 32'd0);
      bus.res_ready = 1'b1;
      step();
      bus.res_ready = 1'b0;
      @(negedge clk);
      check_val({name, "_res_valid_drop"}, 32'(bus.res_valid), 32'd0);
    end else begin
      step();
      @(negedge clk);
      check_val({name, "_no_late_res"}, 32'(bus.res_valid), 32'd0);
    end
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0;
    bus.req_rob_id = 3'd0;
    bus.dmem_rdata = 32'd0;
    bus.dmem_resp = 1'b0;
    bus.res_ready = 1'b0;

    // Reset state
    step();
    @(negedge clk);
    check_val("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_val("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_val("rst_masks", 32'({bus.dmem_rmask, bus.dmem_wmask}), 32'd0);
    check_val("rst_dmem_addr", bus.dmem_addr, 32'd0);
    check_val("rst_res_value", bus.res_value, 32'd0);
    step();
    rst = 1'b0;

    // Byte loads, top lane
    run_access("lb", 1'b0, 3'b000, 32'h0000_1003, 32'd0, 3'd3, 32'h80FF_0000, 1,
               4'b1000, 32'd0, 32'hFFFF_FF80);
    run_access("lbu", 1'b0, 3'b100, 32'h0000_1003, 32'd0, 3'd4, 32'h80FF_0000, 1,
               4'b1000, 32'd0, 32'h0000_0080);
    // Half store, upper lanes, 5-cycle response delay
    run_access("sh", 1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 3'd1, 32'h5555_5555, 5,
               4'b1100, 32'hBEEF_0000, 32'd0);

    // Misaligned word load and half store
    mis_access("lw_mis", 1'b0, 3'b010, 32'h0000_3001, 3'd2);
    mis_access("sh_mis", 1'b1, 3'b001, 32'h0000_3003, 3'd7);

    // Flush during MEM: load dropped, store delivered
    flush_case("fl_ld", 1'b0);
    flush_case("fl_st", 1'b1);

    // DONE held with res_ready low while a second request waits
    drive_req(1'b0, 3'b001, 32'h0000_5002, 32'd0, 3'd2);
    step();
    bus.req_valid = 1'b0;
    bus.dmem_resp = 1'b1;
    bus.dmem_rdata = 32'h8001_7FFF;
    step();
    bus.dmem_resp = 1'b0;
    bus.dmem_rdata = 32'd0;
    drive_req(1'b0, 3'b100, 32'h0000_5001, 32'd0, 3'd6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val($sformatf("hold_valid_%0d", i), 32'(bus.res_valid), 32'd1);
      check_val($sformatf("hold_value_%0d", i), bus.res_value, 32'hFFFF_8001);
      check_val($sformatf("hold_rob_%0d", i), 32'(bus.res_rob_id), 32'd2);
      check_val($sformatf("hold_rmask_%0d", i), 32'(bus.res_rmask), 32'b1100);
      check_val($sformatf("hold_rdata_%0d", i), bus.res_rdata, 32'h8001_7FFF);
      check_val($sformatf("hold_addr_%0d", i), bus.res_addr, 32'h0000_5000);
      check_val($sformatf("hold_ready_%0d", i), 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    check_val("hold_valid_at_ready", 32'(bus.res_valid), 32'd1);
    step();
    bus.res_ready = 1'b0;
    @(negedge clk);
    check_val("hold_valid_drop", 32'(bus.res_valid), 32'd0);
    check_val("queued_req_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_val("queued_rmask", 32'(bus.dmem_rmask), 32'b0010);
    check_val("queued_addr", bus.dmem_addr, 32'h0000_5000);
    bus.dmem_resp = 1'b1;
    bus.dmem_rdata = 32'h0000_AB00;
    step();
    bus.dmem_resp = 1'b0;
    @(negedge clk);
    check_val("queued_value", bus.res_value, 32'h0000_00AB);
    check_val("queued_rob", 32'(bus.res_rob_id), 32'd6);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;

    // Flush of a load waiting in DONE
    drive_req(1'b0, 3'b010, 32'h0000_7000, 32'd0, 3'd4);
    step();
    bus.req_valid = 1'b0;
    bus.dmem_resp = 1'b1;
    bus.dmem_rdata = 32'h1122_3344;
    step();
    bus.dmem_resp = 1'b0;
    @(negedge clk);
    check_val("done_fl_valid", 32'(bus.res_valid), 32'd1);
    check_val("done_fl_value", bus.res_value, 32'h1122_3344);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    check_val("done_fl_drop", 32'(bus.res_valid), 32'd0);
    check_val("done_fl_ready", 32'(bus.req_ready), 32'd1);
    step();

    // Reset during MEM, then a stray response
    drive_req(1'b0, 3'b010, 32'h0000_6000, 32'd0, 3'd1);
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_val("rmem_rmask", 32'(bus.dmem_rmask), 32'b1111);
    step();
    rst = 1'b1;
    @(negedge clk);
    check_val("rmem_ready_in_rst", 32'(bus.req_ready), 32'd0);
    step();
    rst = 1'b0;
    bus.dmem_resp = 1'b1;
    bus.dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_val("rmem_masks", 32'({bus.dmem_rmask, bus.dmem_wmask}), 32'd0);
    check_val("rmem_addr", bus.dmem_addr, 32'd0);
    check_val("rmem_wdata", bus.dmem_wdata, 32'd0);
    check_val("rmem_res_valid", 32'(bus.res_valid), 32'd0);
    step();
    bus.dmem_resp = 1'b0;
    @(negedge clk);
    check_val("stray_res_valid", 32'(bus.res_valid), 32'd0);
    check_val("stray_ready", 32'(bus.req_ready), 32'd1);
    step();
    run_access("lw_after_rst", 1'b0, 3'b010, 32'h0000_6004, 32'd0, 3'd0, 32'hCAFE_BABE, 2,
               4'b1111, 32'd0, 32'hCAFE_BABE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
